// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32IF fetch sequencer with PC, imem handshake and redirect.
// Ports: clk/rst, redirect_*, stall_in, mem_* (req/addr/ready/rdata), if_*.
//
// Purpose
//   Owns the fetch PC and runs a req/ready handshake to a variable-latency
//   instruction memory. Fetched words are presented to decode on if_* with
//   a valid/stall handshake. Redirects from execute flush fetch and discard
//   any wrong-path request still in flight.
//
// Port summary
//   clk, rst             clock (rising edge), async active-high reset
//   redirect_valid/pc    taken branch/jal/jalr target from execute
//   stall_in             decode cannot accept if_* this cycle
//   mem_req/mem_addr     instruction memory request and address
//   mem_ready/mem_rdata  memory completion and instruction word
//   if_valid/pc/instr    instruction presented to decode
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        BUSY,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        ifv_q, ifv_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifins_q, ifins_d;
    logic        skv_q, skv_d;
    logic [31:0] skpc_q, skpc_d;
    logic [31:0] skins_q, skins_d;

    logic out_free;
    logic consume;
    logic arrive;
    logic pend;

    // Redirect targets are word aligned; the low bits are dropped.
    logic unused_rpc_lo;
    assign unused_rpc_lo = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ifv_q   <= 1'b0;
            ifpc_q  <= 32'h0;
            ifins_q <= 32'h0;
            skv_q   <= 1'b0;
            skpc_q  <= 32'h0;
            skins_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ifv_q   <= ifv_d;
            ifpc_q  <= ifpc_d;
            ifins_q <= ifins_d;
            skv_q   <= skv_d;
            skpc_q  <= skpc_d;
            skins_q <= skins_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        ifv_d    = ifv_q;
        ifpc_d   = ifpc_q;
        ifins_d  = ifins_q;
        skv_d    = skv_q;
        skpc_d   = skpc_q;
        skins_d  = skins_q;
        mem_req  = 1'b0;
        mem_addr = pc_q;

        out_free = !ifv_q || !stall_in;
        consume  = ifv_q && !stall_in;

        unique case (state_q)
            BOOT: begin
                mem_req  = 1'b0;
                mem_addr = pc_q;
            end
            FETCH: begin
                mem_req  = out_free && !skv_q;
                mem_addr = pc_q;
            end
            BUSY, DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            default: begin
                mem_req  = 1'b0;
                mem_addr = pc_q;
            end
        endcase

        // Correct-path data arriving this cycle (DRAIN data is dropped).
        arrive = mem_req && mem_ready
                 && ((state_q == FETCH) || (state_q == BUSY));
        pend   = mem_req && !mem_ready;

        if (redirect_valid) begin
            pc_d  = {redirect_pc[31:2], 2'b00};
            ifv_d = 1'b0;
            skv_d = 1'b0;
            if (pend) begin
                state_d = DRAIN;
                // Entering from FETCH: capture the address still on the bus.
                if (state_q == FETCH) begin
                    addr_d = pc_q;
                end
            end else begin
                state_d = FETCH;
            end
        end else begin
            if (arrive) begin
                pc_d = pc_q + 32'd4;
            end

            if (skv_q) begin
                if (consume) begin
                    ifv_d   = 1'b1;
                    ifpc_d  = skpc_q;
                    ifins_d = skins_q;
                    skv_d   = 1'b0;
                end
            end else if (arrive) begin
                if (out_free) begin
                    ifv_d   = 1'b1;
                    ifpc_d  = mem_addr;
                    ifins_d = mem_rdata;
                end else begin
                    skv_d   = 1'b1;
                    skpc_d  = mem_addr;
                    skins_d = mem_rdata;
                end
            end else if (consume) begin
                ifv_d = 1'b0;
            end

            unique case (state_q)
                BOOT: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (pend) begin
                        state_d = BUSY;
                        addr_d  = pc_q;
                    end
                end
                BUSY, DRAIN: begin
                    if (mem_ready) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign if_valid = ifv_q;
    assign if_pc    = ifpc_q;
    assign if_instr = ifins_q;

endmodule
